// File: rtl/dvs_ravens_pkg.sv
// Shared definitions for the DVS event path.
//
// Contents:
//   EVENT_BITS              width of one AER event word as written into the event FIFO
//   CLK_PERIOD_NS           nominal system clock period
//   DEFAULT_MAX_HOLD_CYCLES default bound on how long one requester may own the FIFO bus
//   arb_state_t             state encoding of the FIFO bus arbiter
package dvs_ravens_pkg;

    localparam int unsigned EVENT_BITS              = 16;
    localparam int unsigned CLK_PERIOD_NS           = 10;
    localparam int unsigned DEFAULT_MAX_HOLD_CYCLES = 64;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker.
//
// Searches the request vector starting at last_idx+1 (modulo NUM_REQ) and returns the first
// asserted requester. Suitable for any shared resource with a rotating priority pointer.
//
// Ports:
//   req            in   NUM_REQ   request vector
//   last_idx       in   IDX_BITS  index of the previous winner (search starts after it)
//   winner_onehot  out  NUM_REQ   one-hot winner, zero when no request
//   winner_idx     out  IDX_BITS  winner index, zero when no request
//   valid          out  1         at least one request present
module rr_priority_select #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] last_idx,
    output logic [NUM_REQ-1:0]  winner_onehot,
    output logic [IDX_BITS-1:0] winner_idx,
    output logic                valid
);

    always_comb begin
        int unsigned cand;
        cand          = 0;
        winner_onehot = '0;
        winner_idx    = '0;
        valid         = 1'b0;
        // Offset NUM_REQ wraps back to last_idx itself, so the previous owner is considered last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_idx) + off) % NUM_REQ;
            if (!valid && req[cand[IDX_BITS-1:0]]) begin
                valid                               = 1'b1;
                winner_idx                          = cand[IDX_BITS-1:0];
                winner_onehot[cand[IDX_BITS-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dvs_fifo_bus_arbiter.sv
// Round-robin arbiter sharing the event-FIFO write port among NUM_REQ AER interfaces.
//
// One requester owns the bus at a time; it may write exactly one event per grant and may hold
// the grant for at most MAX_HOLD_CYCLES cycles. Grants are only issued while the FIFO has room.
//
// Ports:
//   clk           in   1                      system clock
//   rst_n         in   1                      asynchronous active-low reset
//   fifo_req      in   NUM_REQ                per-requester bus request
//   fifo_bus_wr   in   NUM_REQ                per-requester write strobe (legal only while granted)
//   fifo_event    in   NUM_REQ x EVENT_BITS   per-requester event word
//   fifo_full     in   1                      downstream FIFO full
//   fifo_grant    out  NUM_REQ                one-hot grant (registered)
//   fifo_wr_en    out  1                      FIFO write enable, single-cycle pulse (registered)
//   fifo_wr_data  out  EVENT_BITS             FIFO write data (registered)
//   owner_idx     out  IDX_BITS               current / last granted requester
//   event_count   out  32                     events written, wraps
//   err_flags     out  3                      sticky: [0] extra write, [1] write w/o grant,
//                                             [2] hold timeout
module dvs_fifo_bus_arbiter
    import dvs_ravens_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_HOLD_CYCLES = DEFAULT_MAX_HOLD_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         fifo_req,
    input  logic [NUM_REQ-1:0]         fifo_bus_wr,
    input  logic [EVENT_BITS-1:0]      fifo_event [NUM_REQ],
    input  logic                       fifo_full,
    output logic [NUM_REQ-1:0]         fifo_grant,
    output logic                       fifo_wr_en,
    output logic [EVENT_BITS-1:0]      fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0] owner_idx,
    output logic [31:0]                event_count,
    output logic [2:0]                 err_flags
);

    localparam int unsigned IDX_BITS  = $clog2(NUM_REQ);
    localparam int unsigned HOLD_BITS = $clog2(MAX_HOLD_CYCLES + 1);

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_BITS-1:0]    owner_q, owner_d;
    logic                   wr_en_q, wr_en_d;
    logic [EVENT_BITS-1:0]  wr_data_q, wr_data_d;
    logic [31:0]            count_q, count_d;
    logic [2:0]             err_q, err_d;
    logic [HOLD_BITS-1:0]   hold_q, hold_d;
    logic                   written_q, written_d;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_BITS-1:0]    pick_idx;
    logic                   pick_valid;

    rr_priority_select #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_select (
        .req           (fifo_req),
        .last_idx      (owner_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .valid         (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        err_d     = err_q;
        hold_d    = hold_q;
        written_d = written_q;

        // Strobes from any requester not currently seeing its grant are ignored but flagged.
        if (|(fifo_bus_wr & ~grant_q)) begin
            err_d[1] = 1'b1;
        end

        unique case (state_q)
            // RELEASE already has all grants low for its single cycle, so it arbitrates like
            // IDLE; this keeps the gap between back-to-back grants at exactly one cycle.
            StIdle, StRelease: begin
                grant_d   = '0;
                hold_d    = '0;
                written_d = 1'b0;
                state_d   = StIdle;
                if (pick_valid && !fifo_full) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    state_d = StGrant;
                end
            end

            StGrant: begin
                hold_d = hold_q + 1'b1;

                if (fifo_bus_wr[owner_q]) begin
                    if (!written_q) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = fifo_event[owner_q];
                        count_d   = count_q + 32'd1;
                        written_d = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end

                // A voluntary release wins over a timeout landing on the same cycle.
                if (!fifo_req[owner_q]) begin
                    grant_d = '0;
                    state_d = StRelease;
                end else if ((32'(hold_q) + 32'd1) >= MAX_HOLD_CYCLES) begin
                    err_d[2] = 1'b1;
                    grant_d  = '0;
                    state_d  = StRelease;
                end
            end

            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            owner_q   <= IDX_BITS'(NUM_REQ - 1);
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            count_q   <= '0;
            err_q     <= '0;
            hold_q    <= '0;
            written_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            written_q <= written_d;
        end
    end

    assign fifo_grant   = grant_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign owner_idx    = owner_q;
    assign event_count  = count_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
module tb_dvs_fifo_bus_arbiter;
    import dvs_ravens_pkg::*;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned MAX_HOLD = 64;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    bus_wr;
    logic [EVENT_BITS-1:0] ev [NUM_REQ];
    logic                  full;
    logic [NUM_REQ-1:0]    grant;
    logic                  wr_en;
    logic [EVENT_BITS-1:0] wr_data;
    logic [1:0]            owner;
    logic [31:0]           count;
    logic [2:0]            err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EVENT_BITS-1:0] exp_q [$];

    dvs_fifo_bus_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MAX_HOLD_CYCLES (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_req     (req),
        .fifo_bus_wr  (bus_wr),
        .fifo_event   (ev),
        .fifo_full    (full),
        .fifo_grant   (grant),
        .fifo_wr_en   (wr_en),
        .fifo_wr_data (wr_data),
        .owner_idx    (owner),
        .event_count  (count),
        .err_flags    (err)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_data), 32'hDEAD);
            end else begin
                check("write_data", 32'(wr_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int hi;
        rst_n  = 1'b0;
        req    = '0;
        bus_wr = '0;
        full   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) ev[i] = '0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_owner", 32'(owner), 32'h3);
        check("rst_count", count, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: single requester 2, one write, release
        req[2] = 1'b1;
        tick();
        check("t1_grant", 32'(grant), 32'b0100);
        check("t1_owner", 32'(owner), 32'h2);
        bus_wr[2] = 1'b1;
        ev[2]     = 16'h01A5;
        exp_q.push_back(16'h01A5);
        tick();
        check("t1_wr_en", 32'(wr_en), 32'h1);
        check("t1_grant_hold", 32'(grant), 32'b0100);
        bus_wr[2] = 1'b0;
        req[2]    = 1'b0;
        tick();
        check("t1_release_grant", 32'(grant), 32'h0);
        check("t1_wr_pulse_end", 32'(wr_en), 32'h0);
        check("t1_count", count, 32'h1);
        tick();
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_err", 32'(err), 32'h0);

        // 2: all request from reset, each drops and re-requests after its grant
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t2_rst_count", count, 32'h0);
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t2_rr_grant", 32'(grant), 32'(1 << (k % 4)));
            req[k % 4] = 1'b0;
            tick();
            check("t2_gap", 32'(grant), 32'h0);
            if (k < 4) req[k % 4] = 1'b1;
            else       req = '0;
            tick();
        end
        check("t2_idle", 32'(grant), 32'h0);

        // 3: FIFO full withholds the grant
        full   = 1'b1;
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_full_no_grant", 32'(grant), 32'h0);
        end
        full = 1'b0;
        tick();
        check("t3_grant_after_full", 32'(grant), 32'b0010);
        req[1] = 1'b0;
        tick();
        tick();

        // 4: double write in one grant, then write without grant
        req[2] = 1'b1;
        tick();
        check("t4_grant", 32'(grant), 32'b0100);
        bus_wr[2] = 1'b1;
        ev[2]     = 16'h00F0;
        exp_q.push_back(16'h00F0);
        tick();
        bus_wr[2] = 1'b0;
        tick();
        bus_wr[2] = 1'b1;
        ev[2]     = 16'h00F1;
        tick();
        bus_wr[2] = 1'b0;
        check("t4_dropped_wr_en", 32'(wr_en), 32'h0);
        check("t4_err0", 32'(err[0]), 32'h1);
        check("t4_count", count, 32'h1);
        check("t4_err1_clear", 32'(err[1]), 32'h0);
        bus_wr[3] = 1'b1;
        ev[3]     = 16'h0333;
        tick();
        bus_wr[3] = 1'b0;
        check("t4_nogrant_wr_en", 32'(wr_en), 32'h0);
        check("t4_err1", 32'(err[1]), 32'h1);
        req[2] = 1'b0;
        tick();
        tick();

        // 5: hold timeout with requester 1 pending
        req = 4'b0011;
        tick();
        check("t5_grant0", 32'(grant), 32'b0001);
        hi = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant == 4'b0001) hi++;
            else break;
        end
        check("t5_hold_len", 32'(hi), 32'(MAX_HOLD));
        check("t5_forced_low", 32'(grant), 32'h0);
        check("t5_err2", 32'(err[2]), 32'h1);
        tick();
        check("t5_next_grant", 32'(grant), 32'b0010);
        req = '0;
        tick();
        tick();

        // 6: asynchronous reset mid-grant discards the in-flight write
        req[2] = 1'b1;
        tick();
        check("t6_grant", 32'(grant), 32'b0100);
        bus_wr[2] = 1'b1;
        ev[2]     = 16'h02AA;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'h0);
        check("t6_async_wr_en", 32'(wr_en), 32'h0);
        check("t6_async_count", count, 32'h0);
        check("t6_async_err", 32'(err), 32'h0);
        check("t6_async_owner", 32'(owner), 32'h3);
        bus_wr[2] = 1'b0;
        req       = 4'b0101;
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart_grant0", 32'(grant), 32'b0001);
        check("t6_no_write", 32'(wr_en), 32'h0);
        req = '0;
        tick();
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvs_fifo_bus_arbiter.md
Name: dvs_fifo_bus_arbiter

Overview:
Round-robin arbiter that shares the single event-FIFO write port among NUM_REQ AER-to-event interfaces. Each interface uses the fifo_req/fifo_grant/fifo_bus_wr/fifo_event handshake. The arbiter grants one requester at a time and muxes that requester's event onto the FIFO write port. It withholds grants while the FIFO is full, and it enforces the rules one write per grant and bounded grant hold time.

Parameters:
NUM_REQ, 4, number of requesting interfaces (2..16)
MAX_HOLD_CYCLES, 64, cycles a requester may hold grant before forced release
IDX_BITS, $clog2(NUM_REQ), derived width of owner index (localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
fifo_req  input  NUM_REQ  per-requester bus request
fifo_bus_wr  input  NUM_REQ  per-requester write strobe (valid only while granted)
fifo_event  input  NUM_REQ x EVENT_BITS  per-requester event word (unpacked array)
fifo_full  input  1  downstream FIFO full flag
fifo_grant  output  NUM_REQ  one-hot grant, registered
fifo_wr_en  output  1  FIFO write enable, registered
fifo_wr_data  output  EVENT_BITS  FIFO write data, registered
owner_idx  output  IDX_BITS  index of current/last granted requester
event_count  output  32  total events written, wraps at 2^32
err_flags  output  3  sticky: [0] extra write in grant, [1] write without grant, [2] hold timeout

Behaviour:
- Reset (async assert, sync deassert assumed upstream) sets: fifo_grant=0, fifo_wr_en=0, fifo_wr_data=0, owner_idx=NUM_REQ-1 (so requester 0 has priority first), event_count=0, err_flags=0, state=IDLE, hold counter=0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE
  - If |fifo_req and !fifo_full: choose the first asserted requester searching from owner_idx+1 modulo NUM_REQ.
  - Register owner_idx and the one-hot fifo_grant on the next edge. Latency is 1 cycle from fifo_req sampled high to fifo_grant high.
  - If fifo_full, or no request: stay in IDLE with grant low.
- GRANT
  - fifo_grant[owner] stays high while fifo_req[owner]=1.
  - First cycle with fifo_bus_wr[owner]=1: next edge fifo_wr_en=1 and fifo_wr_data=fifo_event[owner] (1-cycle write latency); event_count increments.
  - Later fifo_bus_wr[owner] pulses in the same grant are dropped and set err_flags[0].
  - fifo_req[owner] falling leads to RELEASE, with the grant deasserted on that same edge.
  - Hold counter increments each GRANT cycle. On reaching MAX_HOLD_CYCLES: set err_flags[2], force grant low, go to RELEASE.
- RELEASE
  - Exactly one cycle with all grants low, which guarantees the requester sees the grant negedge.
  - Then go to IDLE. Arbitration restarts after owner_idx, giving round-robin fairness.
- fifo_bus_wr[i]=1 while fifo_grant[i]=0 is ignored (no write) and sets err_flags[1].
- fifo_wr_en is a single-cycle pulse. Write and grant-release in the same cycle are both honoured.
- A grant is issued only when !fifo_full. The arbiter is the sole writer and allows one write per grant, so the FIFO cannot overflow. fifo_full asserting mid-grant does not revoke the grant.
- A requester that drops fifo_req before ever writing releases normally (no error, no count).
- Simultaneous requests: the lowest index after owner_idx wins. A requester re-requesting immediately still waits behind all other pending requesters.
- Asserting rst_n low mid-grant clears all outputs asynchronously. Any in-flight event is discarded.
- err_flags clear only on reset.

Decomposition:
- dvs_ravens_pkg: add an arb_state_t enum (IDLE, GRANT, RELEASE) and DEFAULT_MAX_HOLD_CYCLES. Reuse the existing EVENT_BITS and CLK_PERIOD_NS.
- Sub-module rr_priority_select: combinational round-robin picker. Inputs are the request vector and last index; outputs are the one-hot winner, winner index and valid. It is reusable for other shared resources.

Test Plan:
1. Single requester 2 asserts req, writes event 'h1A5 one cycle after grant, drops req -> grant[2] one cycle after req; fifo_wr_en pulse with data 'h1A5; event_count=1; one cycle of grant low; err_flags=0.
2. All 4 requesters request continuously from reset -> grants in order 0,1,2,3,0, each separated by a one-cycle RELEASE gap; never more than one grant bit high.
3. fifo_full=1 while req[1]=1 for 10 cycles, then deasserted -> no grant during the full period; grant[1] on the first cycle after fifo_full falls.
4. Granted requester pulses bus_wr twice with 'h0F0 then 'h0F1 -> only 'h0F0 written; err_flags[0]=1; event_count=1. Requester 3 writing without a grant -> no fifo_wr_en; err_flags[1]=1.
5. Requester holds req for 100 cycles with MAX_HOLD_CYCLES=64 -> grant drops after 64 cycles; err_flags[2]=1; the next pending requester is granted after the RELEASE cycle.
6. rst_n pulsed low mid-grant after bus_wr -> outputs zero asynchronously; no fifo_wr_en afterward; after release, arbitration restarts at requester 0.
